// File: rtl/lfgm_pkg.sv
// Shared constants and types for the life-game display fetch path.
package lfgm_pkg;

  localparam int LFGM_CELL_W  = 80;   // cells per row
  localparam int LFGM_CELL_H  = 60;   // cell rows per frame
  localparam int LFGM_CELL_PX = 8;    // pixels per cell edge
  localparam int LFGM_ADR_W   = 13;   // cell-store address width
  localparam int LFGM_COL_W   = 7;    // column index width
  localparam int LFGM_ROW_W   = 6;    // row index width

  typedef logic [11:0] rgb12_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/lfgm_dly_pipe.sv
// Read-return alignment pipe: a MAX_DLY-deep shift register of (valid, col).
// The tap selects which stage is presented as the returning cell, and flush
// drops every in-flight valid so aborted reads never land in the line buffer.
module lfgm_dly_pipe #(
  parameter int MAX_DLY = 15,
  parameter int COL_W   = 7,
  parameter int TAP_W   = $clog2(MAX_DLY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [COL_W-1:0] in_col,
  input  logic [TAP_W-1:0] tap,
  output logic             tap_vld,
  output logic [COL_W-1:0] tap_col,
  output logic             pending
);

  logic [MAX_DLY-1:0] vld_sr;
  logic [COL_W-1:0]   col_sr [MAX_DLY];
  logic [TAP_W-1:0]   tap_idx;

  // Shift valid and column every clock; flush clears only the valids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr <= '0;
      for (int i = 0; i < MAX_DLY; i++) col_sr[i] <= '0;
    end else begin
      vld_sr    <= flush ? '0 : {vld_sr[MAX_DLY-2:0], in_vld};
      col_sr[0] <= in_col;
      for (int i = 1; i < MAX_DLY; i++) col_sr[i] <= col_sr[i-1];
    end
  end

  // Stage k holds a strobe issued k+1 clocks ago, so latency d taps stage d-1.
  assign tap_idx = tap - TAP_W'(1);
  assign tap_vld = vld_sr[tap_idx];
  assign tap_col = col_sr[tap_idx];

  // Outstanding returns are only those at or before the tap; deeper stages are dead.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < MAX_DLY; i++) begin
      if ((TAP_W'(i) < tap) && vld_sr[i]) pending = 1'b1;
    end
  end

endmodule

// File: rtl/lfgm_disp_fetch.sv
// Display-side fetch of life-game cells into a ping-pong line buffer and
// expansion into 640x480 VGA pixels (8x8 per cell, 12-bit RGB).
// Optional macro LFGM_GRID_EN draws dead-cell grid lines in GRID_RGB.
module lfgm_disp_fetch
  import lfgm_pkg::*;
#(
  parameter int     CELL_W   = 80,
  parameter int     CELL_H   = 60,
  parameter int     MAX_DLY  = 15,
  parameter rgb12_t FG_RGB   = 12'hFFF,
  parameter rgb12_t BG_RGB   = 12'h000,
  parameter rgb12_t GRID_RGB = 12'h333
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic                  line_start,
  input  logic [9:0]            vis_y,
  input  logic [9:0]            pix_x,
  input  logic                  pix_de,
  output logic [LFGM_ADR_W-1:0] disp_rd_adr,
  output logic                  disp_rd_en,
  input  logic                  disp_wr_dt,
  input  logic [15:0]           dly,
  output rgb12_t                pix_rgb,
  output logic                  busy,
  output logic                  ovr_err
);

  localparam int DLY_W = $clog2(MAX_DLY + 1);

  fetch_state_t          state;
  logic [LFGM_COL_W-1:0] col;
  logic [LFGM_ADR_W-1:0] base;
  logic                  fetch_bank;
  logic [DLY_W-1:0]      eff_dly_q;
  logic                  line_trig;
  logic [LFGM_ROW_W-1:0] line_row;
  logic                  tap_vld;
  logic [LFGM_COL_W-1:0] tap_col;
  logic                  pending;
  logic [CELL_W-1:0]     bank0;
  logic [CELL_W-1:0]     bank1;

  // Latency 0 is meaningless for a registered memory; anything deeper than the pipe saturates.
  function automatic logic [DLY_W-1:0] clamp_dly(input logic [15:0] d);
    if (d == 16'd0)               return DLY_W'(1);
    else if (d > 16'(MAX_DLY))    return DLY_W'(MAX_DLY);
    else                          return d[DLY_W-1:0];
  endfunction

  // row*80 as row*64 + row*16: two constant shifts and one add.
  function automatic logic [LFGM_ADR_W-1:0] row_base(input logic [LFGM_ROW_W-1:0] r);
    return LFGM_ADR_W'({r, 6'b0}) + LFGM_ADR_W'({r, 4'b0});
  endfunction

  // A line in row k's first scanline prefetches row k+1, except after the last row.
  assign line_trig = line_start && (vis_y[2:0] == 3'd0) &&
                     (vis_y[9:3] < 7'(CELL_H - 1));
  assign line_row  = vis_y[8:3] + LFGM_ROW_W'(1);

  // Fetch sequencer: frame_start always restarts row 0; line triggers only start from IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      disp_rd_en  <= 1'b0;
      disp_rd_adr <= '0;
      col         <= '0;
      base        <= '0;
      fetch_bank  <= 1'b0;
      eff_dly_q   <= DLY_W'(1);
      ovr_err     <= 1'b0;
    end else if (frame_start) begin
      if (state != IDLE) ovr_err <= 1'b1;
      state       <= ISSUE;
      busy        <= 1'b1;
      disp_rd_en  <= 1'b1;
      disp_rd_adr <= '0;
      col         <= '0;
      base        <= '0;
      fetch_bank  <= 1'b0;
      eff_dly_q   <= clamp_dly(dly);
    end else begin
      case (state)
        IDLE: begin
          if (line_trig) begin
            state       <= ISSUE;
            busy        <= 1'b1;
            disp_rd_en  <= 1'b1;
            disp_rd_adr <= row_base(line_row);
            col         <= '0;
            base        <= row_base(line_row);
            fetch_bank  <= line_row[0];
            eff_dly_q   <= clamp_dly(dly);
          end
        end
        ISSUE: begin
          if (line_trig) ovr_err <= 1'b1;
          if (col == LFGM_COL_W'(CELL_W - 1)) begin
            state      <= DRAIN;
            disp_rd_en <= 1'b0;
          end else begin
            col         <= col + LFGM_COL_W'(1);
            disp_rd_adr <= base + LFGM_ADR_W'(col) + LFGM_ADR_W'(1);
          end
        end
        DRAIN: begin
          if (line_trig) ovr_err <= 1'b1;
          if (!pending) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  lfgm_dly_pipe #(
    .MAX_DLY (MAX_DLY),
    .COL_W   (LFGM_COL_W),
    .TAP_W   (DLY_W)
  ) u_dly_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (frame_start),
    .in_vld  (disp_rd_en),
    .in_col  (col),
    .tap     (eff_dly_q),
    .tap_vld (tap_vld),
    .tap_col (tap_col),
    .pending (pending)
  );

  // Capture returning cells into the bank of the row being fetched; an abort cycle writes nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank0 <= '0;
      bank1 <= '0;
    end else if (tap_vld && !frame_start) begin
      if (fetch_bank) bank1[tap_col] <= disp_wr_dt;
      else            bank0[tap_col] <= disp_wr_dt;
    end
  end

  // ---- pixel stage p0: cell lookup ----
  logic                  in_range_p0;
  logic [LFGM_COL_W-1:0] cell_idx_p0;
  logic                  cell_p0;
  logic                  grid_p0;
  rgb12_t                dead_rgb_p0;

  assign in_range_p0 = pix_x < 10'(CELL_W * LFGM_CELL_PX);
  assign cell_idx_p0 = in_range_p0 ? pix_x[9:3] : '0;
  assign cell_p0     = vis_y[3] ? bank1[cell_idx_p0] : bank0[cell_idx_p0];
`ifdef LFGM_GRID_EN
  assign grid_p0     = (pix_x[2:0] == 3'd0) || (vis_y[2:0] == 3'd0);
`else
  assign grid_p0     = 1'b0;
`endif
  assign dead_rgb_p0 = grid_p0 ? GRID_RGB : BG_RGB;

  // ---- pixel stage p1: registered colour ----
  // One registered stage from pixel coordinates to colour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            pix_rgb <= '0;
    else if (!pix_de)      pix_rgb <= '0;
    else if (!in_range_p0) pix_rgb <= BG_RGB;
    else if (cell_p0)      pix_rgb <= FG_RGB;
    else                   pix_rgb <= dead_rgb_p0;
  end

endmodule
